// File: rtl/frame_start_sequencer.sv
// Frame-start sequencer: walks the pattern ROM, streams the payload words,
// then enforces an inter-frame gap before the next start can be accepted.
// The output word register uses a valid/ready hold. A frame is
// PATTERN_LEN ROM words followed by PAYLOAD_LEN payload words.
// Optional feature macro: FRAME_CRC_EN. When it is defined, a CRC-16-CCITT
// word (poly 0x1021, init 0xFFFF) over the payload is appended, and that
// word carries EOF.
module frame_start_sequencer #(
    parameter int PATTERN_LEN = 64,
    parameter int PAYLOAD_LEN = 256,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [5:0]  o_rom_index,
    input  logic [15:0] i_rom_data,
    input  logic [15:0] i_pl_data,
    input  logic        i_pl_valid,
    output logic        o_pl_ready,
    output logic [15:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam logic [5:0]  IDX_LAST = 6'(PATTERN_LEN - 1);
    localparam logic [15:0] PL_LEN   = 16'(PAYLOAD_LEN);
    localparam logic [15:0] PL_LAST  = 16'(PAYLOAD_LEN - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam bit          NO_GAP   = (GAP_CYCLES == 0);

    // S_PRIME is a single cycle after a start is accepted. It gives the ROM a
    // full cycle of address-to-data time from the freshly cleared index.
    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_PREAMBLE, S_PAYLOAD, S_CRC, S_DRAIN, S_GAP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_rom_index;
    logic [15:0] r_pl_count;
    logic [7:0]  r_gap_count;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_sof;
    logic        r_eof;
    logic        r_frame_done;
    logic        w_load;
    logic        w_pl_fire;
    logic        w_pl_last;

    // The output register may take a new word when it is empty or being drained.
    assign w_load    = !r_valid || i_ready;
    assign w_pl_fire = o_pl_ready && i_pl_valid;
    assign w_pl_last = (r_pl_count == PL_LAST);

`ifdef FRAME_CRC_EN
    logic [15:0] r_crc;

    // Bit-serial CRC-16-CCITT, MSB first, over one 16-bit word.
    function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // CRC accumulator: seeded at frame start, folded in per accepted payload word.
    always_ff @(posedge i_clk) begin
        if (i_rst)                             r_crc <= 16'hFFFF;
        else if (r_state == S_IDLE && i_start) r_crc <= 16'hFFFF;
        else if (w_pl_fire)                    r_crc <= crc16_word(r_crc, i_pl_data);
    end
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_next_state = S_PRIME;
            S_PRIME:    w_next_state = S_PREAMBLE;
            S_PREAMBLE: if (w_load && r_rom_index == IDX_LAST) w_next_state = S_PAYLOAD;
`ifdef FRAME_CRC_EN
            S_PAYLOAD:  if (w_pl_fire && w_pl_last) w_next_state = S_CRC;
            S_CRC:      if (w_load) w_next_state = S_DRAIN;
`else
            S_PAYLOAD:  if (w_pl_fire && w_pl_last) w_next_state = S_DRAIN;
`endif
            S_DRAIN:    if (w_load) w_next_state = NO_GAP ? S_IDLE : S_GAP;
            S_GAP:      if (r_gap_count == GAP_LAST) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // State-derived outputs. The payload handshake only opens while the output register can load.
    always_comb begin
        o_busy     = (r_state != S_IDLE);
        o_pl_ready = (r_state == S_PAYLOAD) && w_load && (r_pl_count < PL_LEN);
    end

    // Datapath: ROM index, counters and the output word register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rom_index <= '0;
            r_pl_count  <= '0;
            r_gap_count <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rom_index <= '0;
                        r_pl_count  <= '0;
                        r_gap_count <= '0;
                    end
                end
                S_PREAMBLE: begin
                    if (w_load) begin
                        r_data  <= i_rom_data;
                        r_valid <= 1'b1;
                        r_sof   <= (r_rom_index == 6'd0);
                        r_eof   <= 1'b0;
                        // Hold on the last index so it never wraps inside a frame.
                        if (r_rom_index != IDX_LAST) r_rom_index <= r_rom_index + 6'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (w_pl_fire) begin
                        r_data     <= i_pl_data;
                        r_valid    <= 1'b1;
                        r_sof      <= 1'b0;
`ifdef FRAME_CRC_EN
                        r_eof      <= 1'b0;
`else
                        r_eof      <= w_pl_last;
`endif
                        r_pl_count <= r_pl_count + 16'd1;
                    end else if (w_load) begin
                        // Source starved: emit a bubble rather than repeat a word.
                        r_valid <= 1'b0;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b0;
                    end
                end
`ifdef FRAME_CRC_EN
                S_CRC: begin
                    if (w_load) begin
                        r_data  <= r_crc;
                        r_valid <= 1'b1;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b1;
                    end
                end
`endif
                S_DRAIN: begin
                    if (w_load) begin
                        r_valid     <= 1'b0;
                        r_sof       <= 1'b0;
                        r_eof       <= 1'b0;
                        r_gap_count <= '0;
                    end
                end
                S_GAP:   r_gap_count <= r_gap_count + 8'd1;
                default: ;
            endcase
        end
    end

    // Frame-done pulse: set on the edge that returns to IDLE. A reset abort never pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_frame_done <= 1'b0;
        else       r_frame_done <= (r_state != S_IDLE) && (w_next_state == S_IDLE);
    end

    assign o_rom_index  = r_rom_index;
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_sof        = r_sof;
    assign o_eof        = r_eof;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_start_sequencer.sv
// Bench for frame_start_sequencer. Expected frame words come from a table
// that is built at the top of the test and compared word by word. Cycle-level
// corner cases are covered by short hand-written sequences.
module tb_frame_start_sequencer;

    localparam int PL  = 4;
    localparam int GAP = 4;
`ifdef FRAME_CRC_EN
    localparam int FW = 64 + PL + 1;
`else
    localparam int FW = 64 + PL;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eof;
    } word_t;

    logic        clk = 1'b0;
    logic        rst, start, ready, pl_valid;
    logic [5:0]  rom_index;
    logic [15:0] rom_data, pl_data, data;
    logic        pl_ready, valid, sof, eof, busy, frame_done;
    logic [15:0] pcnt = 16'd0;

    int errors = 0;
    int checks = 0;
    word_t exp_tab[$];
    word_t got[$];

    always #5 clk = ~clk;

    // Pattern ROM contents; the words the test plan names are pinned.
    function automatic logic [15:0] rom_f(input logic [5:0] i);
        case (i)
            6'd0:    return 16'hABCD;
            6'd1:    return 16'hEF89;
            6'd2:    return 16'hBDE7;
            6'd3:    return 16'hF0A5;
            6'd62:   return 16'h4567;
            6'd63:   return 16'h3210;
            default: return {i, 4'hC, i};
        endcase
    endfunction

    // Byte-wise CRC-16-CCITT reference.
    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [15:0] w);
        logic [7:0] b [2];
        b[0] = w[15:8];
        b[1] = w[7:0];
        for (int k = 0; k < 2; k++) begin
            crc = crc ^ {b[k], 8'h00};
            for (int j = 0; j < 8; j++)
                crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
        end
        return crc;
    endfunction

    assign rom_data = rom_f(rom_index);
    assign pl_data  = pcnt + 16'd1;

    // Payload source: words 1,2,3,... restarting whenever the DUT is idle.
    always @(posedge clk) begin
        if (!busy)                      pcnt <= 16'd0;
        else if (pl_ready && pl_valid)  pcnt <= pcnt + 16'd1;
    end

    // Record every accepted word.
    always @(negedge clk)
        if (valid && ready) got.push_back(word_t'({data, sof, eof}));

    frame_start_sequencer #(.PATTERN_LEN(64), .PAYLOAD_LEN(PL), .GAP_CYCLES(GAP)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_rom_index(rom_index), .i_rom_data(rom_data),
        .i_pl_data(pl_data), .i_pl_valid(pl_valid), .o_pl_ready(pl_ready),
        .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_sof(sof), .o_eof(eof), .o_busy(busy), .o_frame_done(frame_done)
    );

`ifdef FRAME_CRC_EN
    logic        c_start;
    logic [5:0]  c_rom_index;
    logic [15:0] c_rom_data, c_data;
    logic        c_pl_ready, c_valid, c_sof, c_eof, c_busy, c_frame_done;
    word_t       c_got[$];

    assign c_rom_data = rom_f(c_rom_index);

    always @(negedge clk)
        if (c_valid && ready) c_got.push_back(word_t'({c_data, c_sof, c_eof}));

    frame_start_sequencer #(.PATTERN_LEN(64), .PAYLOAD_LEN(1), .GAP_CYCLES(GAP)) u_crc (
        .i_clk(clk), .i_rst(rst), .i_start(c_start),
        .o_rom_index(c_rom_index), .i_rom_data(c_rom_data),
        .i_pl_data(16'h1234), .i_pl_valid(pl_valid), .o_pl_ready(c_pl_ready),
        .o_data(c_data), .o_valid(c_valid), .i_ready(ready),
        .o_sof(c_sof), .o_eof(c_eof), .o_busy(c_busy), .o_frame_done(c_frame_done)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic wait_data(input logic [15:0] v);
        int n = 0;
        while (!(valid && data == v) && n < 300) begin tick(); n++; end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_data: word %h never appeared (timeout), expected within 300 cycles", v);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 400) begin tick(); n++; end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_done: o_frame_done=%b after timeout, expected 1", frame_done);
        end
    endtask

    // Compare the captured words with an expected table, then clear the capture.
    task automatic cmp_frame(input string name, input word_t act[$], input word_t req[$]);
        chk({name, "_len"}, 32'(act.size()), 32'(req.size()));
        for (int i = 0; i < req.size() && i < act.size(); i++) begin
            checks++;
            if (act[i] !== req[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got data=%h sof=%b eof=%b expected data=%h sof=%b eof=%b",
                         name, i, act[i].data, act[i].sof, act[i].eof,
                         req[i].data, req[i].sof, req[i].eof);
            end
        end
    endtask

    initial begin
        logic [15:0] crc;
        int          n;
`ifdef FRAME_CRC_EN
        word_t c_exp[$];
`endif
        // Expected frame table: pattern ROM, payload 1..PL, optional CRC word.
        for (int i = 0; i < 64; i++)
            exp_tab.push_back(word_t'({rom_f(6'(i)), i == 0, 1'b0}));
        crc = 16'hFFFF;
        for (int p = 1; p <= PL; p++) begin
`ifdef FRAME_CRC_EN
            exp_tab.push_back(word_t'({16'(p), 1'b0, 1'b0}));
`else
            exp_tab.push_back(word_t'({16'(p), 1'b0, p == PL}));
`endif
            crc = crc_model(crc, 16'(p));
        end
`ifdef FRAME_CRC_EN
        exp_tab.push_back(word_t'({crc, 1'b0, 1'b1}));
        for (int i = 0; i < 64; i++)
            c_exp.push_back(word_t'({rom_f(6'(i)), i == 0, 1'b0}));
        c_exp.push_back(word_t'({16'h1234, 1'b0, 1'b0}));
        c_exp.push_back(word_t'({crc_model(16'hFFFF, 16'h1234), 1'b0, 1'b1}));
        c_start = 1'b0;
`endif

        rst = 1'b1; start = 1'b0; ready = 1'b1; pl_valid = 1'b1;
        repeat (3) tick();
        chk("reset_state", {rom_index, data, valid, sof, eof, busy, frame_done}, 32'h0);
        rst = 1'b0;
        tick();
        got.delete();

        // Test 1: full frame, latency, no bubbles, gap then frame_done.
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy_after_start", {busy, valid}, 2'b10);
        tick();
        chk("t1_no_word_yet", valid, 0);
        tick();
        chk("t1_first_word", {valid, sof, data}, {1'b1, 1'b1, 16'hABCD});
        n = 1;
        while (n < 200) begin tick(); if (!valid) break; n++; end
        chk("t1_consecutive_words", n, FW);
        n = 1;
        while (!frame_done && n < 20) begin tick(); n++; end
        chk("t1_gap_to_done", n, GAP + 1);
        cmp_frame("t1_frame", got, exp_tab);
        got.delete();

        // Test 4b: start in the frame_done cycle is accepted; word arrives two cycles later.
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_done_clears", {frame_done, busy}, 2'b01);
        tick();
        chk("t4_no_word_yet", valid, 0);
        tick();
        chk("t4_restart_first", {valid, sof, data}, {1'b1, 1'b1, 16'hABCD});

        // Test 2: downstream stall on 0xBDE7.
        wait_data(16'hBDE7);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_hold", {valid, sof, eof, rom_index, data}, {1'b1, 1'b0, 1'b0, 6'd3, 16'hBDE7});
        end
        ready = 1'b1;
        tick();
        chk("t2_resume", {valid, data}, {1'b1, 16'hF0A5});
        wait_done();
        cmp_frame("t2_frame", got, exp_tab);
        got.delete();
        tick();

        // Test 3: payload bubble, plus test 4a: start during PAYLOAD is ignored.
        start = 1'b1; tick(); start = 1'b0;
        wait_data(16'h0001);
        pl_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_bubble", {valid, pl_ready}, 2'b01);
        end
        pl_valid = 1'b1;
        tick();
        chk("t3_resume", {valid, data}, {1'b1, 16'h0002});
        start = 1'b1; tick(); start = 1'b0;
        wait_done();
        cmp_frame("t3_frame", got, exp_tab);
        got.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_start_not_queued", {busy, frame_done, valid}, 3'b000);
        end

        // Test 5: reset mid-preamble aborts without frame_done.
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (rom_index != 6'd30 && n < 100) begin tick(); n++; end
        chk("t5_reach_index30", rom_index, 6'd30);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_abort", {valid, busy, frame_done, rom_index}, 9'h0);
        got.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_done_pulse", {frame_done, busy, valid}, 3'b000);
        end
        start = 1'b1; tick(); start = 1'b0;
        wait_done();
        cmp_frame("t5_frame", got, exp_tab);
        got.delete();

`ifdef FRAME_CRC_EN
        // Test 6: single payload word 0x1234 followed by its CRC word.
        tick();
        c_got.delete();
        c_start = 1'b1; tick(); c_start = 1'b0;
        n = 0;
        while (!c_frame_done && n < 300) begin tick(); n++; end
        chk("t6_done", c_frame_done, 1);
        cmp_frame("t6_crc_frame", c_got, c_exp);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
